exec_stage_mc: RTL
==================

# exec_stage_mc

Parametrised multi-cycle execute stage for the ARM-style pipeline, sitting between the ID/EX pipeline register and the EX/MEM register. It combines a single-cycle ALU path with an iterative shift-add multiplier (MUL/MLA). It computes the branch target and owns the NZCV status register. Unlike the single-cycle stage, it uses a valid/ready handshake so a multiply can stall the front end while later stages apply backpressure.

## Interface
- DATA_LEN, 32: operand/result width; ≥8, even.
- ADDRESS_LEN, 32: PC/branch width; ≥26.
- MUL_BITS, 2: multiplier bits retired per cycle; must divide DATA_LEN (1, 2, 4).

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage can accept.
- PC_in  in  ADDRESS_LEN  PC of the instruction.
- EXE_CMD  in  4  ALU command.
- mul_op  in  2  00 none, 01 MUL, 10 MLA, 11 reserved (treated as none).
- MEM_R_EN, MEM_W_EN  in  1 each  memory access, selects offset as Val2.
- imm  in  1  operand 2 is a pre-rotated immediate on Val_Rm.
- Val_Rn, Val_Rm, Val_Rs  in  DATA_LEN each  operands; MUL: Rm×Rs, MLA adds Rn.
- offset  in  12  memory offset.
- Signed_imm_24  in  24  branch offset.
- carry_in  in  1  current C for ADC/SBC.
- S  in  1  update flags on completion.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- ALU_Res  out  DATA_LEN  result.
- Branch_Address  out  ADDRESS_LEN  PC_in + sext(Signed_imm_24)<<2.
- N_stat, Z_stat, C_stat, V_stat  out  1 each  status register.

## Operation
- Val2: offset zero-extended when MEM_R_EN|MEM_W_EN, else Val_Rm.
- EXE_CMD: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB/CMP/LDR/STR address, 0101 SBC, 0110 AND/TST, 0111 ORR, 1000 EOR; others → result 0. SBC = Rn−Val2−!carry_in.
- C = adder carry-out (SUB: no-borrow). V = signed overflow for add/sub only. Logic ops keep C and V at their previous values.
- Accept when in_valid && in_ready. Inputs are captured on the accept edge. Branch_Address is registered at accept.
- FSM: IDLE → (mul_op none) RESULT; IDLE → (MUL/MLA) MUL_BUSY; MUL_BUSY → RESULT after DATA_LEN/MUL_BITS iterations; RESULT → IDLE when out_ready.
- Multiplier: each cycle, acc += (multiplicand << shift) × next MUL_BITS of Rs. The result is the low DATA_LEN bits. MLA initialises acc = Val_Rn. S on MUL/MLA updates N and Z only; C and V are unchanged.
- in_ready = (state==IDLE) || (state==RESULT && out_ready). This gives back-to-back single-cycle ops at full rate.
- Flags update once, on the cycle the result becomes valid, only if S was set for that op.

## Timing
- Reset: state IDLE, out_valid 0, ALU_Res 0, Branch_Address 0, NZCV 0, accumulator 0.
- ALU op: out_valid rises 1 cycle after accept.
- MUL/MLA: out_valid rises DATA_LEN/MUL_BITS + 1 cycles after accept (17 at defaults).
- Outputs hold stable while out_valid && !out_ready.
- Reset asserted mid-multiply aborts the op; no flags change; out_valid is 0 after release.
- Accept and retire on the same edge: the new result replaces the old without a bubble.

## Configuration
- EXEC_MUL_EARLY_TERM_EN defined: MUL_BUSY exits early when the remaining unconsumed Rs bits are all zero. Latency is then 1 + ceil(msb_index(Rs)+1 / MUL_BITS), minimum 2. Rs=0 completes in 2 cycles.
- Undefined: fixed latency DATA_LEN/MUL_BITS + 1. Results are identical in both modes.

## Structure
- Package exec_pkg: EXE_CMD localparams, mul_op encodings, FSM state enum.
- Sub-module exec_mul_iter: iterative multiplier with start/busy/done. The ALU, flags and FSM stay in the top level.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, S=1 → ALU_Res 0x80000000, N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept.
- MUL 0x0000FFFF × 0x00010001, S=1, MUL_BITS=2, out_ready=1 → 0xFFFFFFFF after 17 cycles; in_ready low for 16 cycles; N=1 and C/V unchanged.
- MLA Rm=3 Rs=5 Rn=7 → 22. With EXEC_MUL_EARLY_TERM_EN, out_valid at cycle 3.
- Hold out_ready=0 for 5 cycles after SUB 5−5 → ALU_Res 0, Z=1 C=1, outputs stable, in_ready low, no second accept.
- Signed_imm_24=0xFFFFFF, PC_in=0x100 → Branch_Address 0xFC. With S=0, flags keep their prior values.
- Drop rst at cycle 8 of a MUL → all outputs 0, state IDLE; the next ADD completes normally.

Source files
------------

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - ALU command codes, multiply op codes and FSM states for exec_stage_mc
package exec_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   localparam logic [1:0] MUL_OP_NONE = 2'b00;
   localparam logic [1:0] MUL_OP_MUL  = 2'b01;
   localparam logic [1:0] MUL_OP_MLA  = 2'b10;
   localparam logic [1:0] MUL_OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1,
      ST_RESULT   = 2'd2
   } exec_state_t;

endpackage

// File: rtl/exec_stage_mc_if.sv
// rtl/exec_stage_mc_if.sv - handshake and operand/result bundle of the multi-cycle execute stage
interface exec_stage_mc_if #(
   parameter int DATA_LEN    = 32,
   parameter int ADDRESS_LEN = 32
);

   logic                   in_valid;
   logic                   in_ready;
   logic [ADDRESS_LEN-1:0] PC_in;
   logic [3:0]             EXE_CMD;
   logic [1:0]             mul_op;
   logic                   MEM_R_EN;
   logic                   MEM_W_EN;
   logic                   imm;
   logic [DATA_LEN-1:0]    Val_Rn;
   logic [DATA_LEN-1:0]    Val_Rm;
   logic [DATA_LEN-1:0]    Val_Rs;
   logic [11:0]            offset;
   logic [23:0]            Signed_imm_24;
   logic                   carry_in;
   logic                   S;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_LEN-1:0]    ALU_Res;
   logic [ADDRESS_LEN-1:0] Branch_Address;
   logic                   N_stat;
   logic                   Z_stat;
   logic                   C_stat;
   logic                   V_stat;

   modport master (
      output in_valid, PC_in, EXE_CMD, mul_op, MEM_R_EN, MEM_W_EN, imm,
             Val_Rn, Val_Rm, Val_Rs, offset, Signed_imm_24, carry_in, S, out_ready,
      input  in_ready, out_valid, ALU_Res, Branch_Address, N_stat, Z_stat, C_stat, V_stat
   );

   modport slave (
      input  in_valid, PC_in, EXE_CMD, mul_op, MEM_R_EN, MEM_W_EN, imm,
             Val_Rn, Val_Rm, Val_Rs, offset, Signed_imm_24, carry_in, S, out_ready,
      output in_ready, out_valid, ALU_Res, Branch_Address, N_stat, Z_stat, C_stat, V_stat
   );

endinterface

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative shift-add multiplier, MUL_BITS multiplier bits per cycle; EXEC_MUL_EARLY_TERM_EN enables early exit
module exec_mul_iter #(
   parameter int DATA_LEN = 32,
   parameter int MUL_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic [DATA_LEN-1:0] i_multiplicand,
   input  logic [DATA_LEN-1:0] i_multiplier,
   input  logic [DATA_LEN-1:0] i_addend,
   output logic                o_busy,
   output logic                o_done,
   output logic [DATA_LEN-1:0] o_product
);

   localparam int ITERS = DATA_LEN / MUL_BITS;
   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   logic [DATA_LEN-1:0] r_acc;
   logic [DATA_LEN-1:0] r_mcand;
   logic [DATA_LEN-1:0] r_mplier;
   logic [CNT_W-1:0]    r_count;
   logic                r_busy;

   logic [DATA_LEN-1:0] w_partial;
   logic [DATA_LEN-1:0] w_acc_next;
   logic [DATA_LEN-1:0] w_mplier_rest;
   logic                w_last;

   // partial product of the shifted multiplicand and the current multiplier digit, built by shift-add
   always_comb begin
      w_partial = '0;
      for (int b = 0; b < MUL_BITS; b++) begin
         if (r_mplier[b]) begin
            w_partial = w_partial + (r_mcand << b);
         end
      end
   end

   assign w_acc_next    = r_acc + w_partial;
   assign w_mplier_rest = r_mplier >> MUL_BITS;

`ifdef EXEC_MUL_EARLY_TERM_EN
   // stop as soon as no set multiplier bits remain beyond the digit being retired
   assign w_last = (r_count == LAST_CNT) || (w_mplier_rest == '0);
`else
   assign w_last = (r_count == LAST_CNT);
`endif

   assign o_busy    = r_busy;
   assign o_done    = r_busy & w_last;
   assign o_product = w_acc_next;

   // load operands on start, then retire one multiplier digit per cycle until the last one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
      end else if (i_start) begin
         r_acc    <= i_addend;
         r_mcand  <= i_multiplicand;
         r_mplier <= i_multiplier;
         r_count  <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << MUL_BITS;
         r_mplier <= w_mplier_rest;
         r_count  <= r_count + 1'b1;
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/exec_stage_mc.sv
// rtl/exec_stage_mc.sv - multi-cycle execute stage: ALU, iterative MUL/MLA, branch target, NZCV; EXEC_MUL_EARLY_TERM_EN enables multiplier early exit
module exec_stage_mc
   import exec_pkg::*;
#(
   parameter int DATA_LEN    = 32,
   parameter int ADDRESS_LEN = 32,
   parameter int MUL_BITS    = 2
) (
   input logic            clk,
   input logic            rst,
   exec_stage_mc_if.slave bus
);

   localparam int MSB = DATA_LEN - 1;

   exec_state_t            r_state;
   exec_state_t            w_state_next;
   logic [DATA_LEN-1:0]    r_alu_res;
   logic [ADDRESS_LEN-1:0] r_branch;
   logic                   r_n;
   logic                   r_z;
   logic                   r_c;
   logic                   r_v;
   logic                   r_mul_s;

   logic                   w_in_ready;
   logic                   w_accept;
   logic                   w_mul_start;
   logic                   w_is_mul;
   logic                   w_is_mla;
   logic [DATA_LEN-1:0]    w_val2;
   logic [DATA_LEN-1:0]    w_add_b;
   logic                   w_add_cin;
   logic                   w_arith;
   logic [DATA_LEN:0]      w_sum;
   logic                   w_alu_v;
   logic [DATA_LEN-1:0]    w_alu_res;
   logic [ADDRESS_LEN-1:0] w_br_off;
   logic [ADDRESS_LEN-1:0] w_branch;
   logic [DATA_LEN-1:0]    w_mul_addend;
   logic                   w_mul_busy;
   logic                   w_mul_done;
   logic [DATA_LEN-1:0]    w_mul_product;
   logic                   w_unused;

   // immediates arrive already rotated on Val_Rm, so imm carries no extra information here
   assign w_unused = ^{bus.imm, w_mul_busy};

   // decode the multiply op; the reserved code behaves like a plain ALU op
   always_comb begin
      w_is_mul = 1'b0;
      w_is_mla = 1'b0;
      case (bus.mul_op)
         MUL_OP_MUL: w_is_mul = 1'b1;
         MUL_OP_MLA: begin
            w_is_mul = 1'b1;
            w_is_mla = 1'b1;
         end
         MUL_OP_NONE, MUL_OP_RSVD: begin
         end
         default: begin
         end
      endcase
   end

   assign w_val2 = (bus.MEM_R_EN | bus.MEM_W_EN) ? DATA_LEN'(bus.offset) : bus.Val_Rm;

   // adder operand setup: subtraction is Rn + ~Val2 + carry so C reads as no-borrow
   always_comb begin
      w_add_b   = w_val2;
      w_add_cin = 1'b0;
      w_arith   = 1'b0;
      case (bus.EXE_CMD)
         CMD_ADD: w_arith = 1'b1;
         CMD_ADC: begin
            w_arith   = 1'b1;
            w_add_cin = bus.carry_in;
         end
         CMD_SUB: begin
            w_arith   = 1'b1;
            w_add_b   = ~w_val2;
            w_add_cin = 1'b1;
         end
         CMD_SBC: begin
            w_arith   = 1'b1;
            w_add_b   = ~w_val2;
            w_add_cin = bus.carry_in;
         end
         default: begin
         end
      endcase
   end

   assign w_sum   = {1'b0, bus.Val_Rn} + {1'b0, w_add_b} + {{DATA_LEN{1'b0}}, w_add_cin};
   assign w_alu_v = (bus.Val_Rn[MSB] == w_add_b[MSB]) && (w_sum[MSB] != bus.Val_Rn[MSB]);

   // single-cycle result selection; unknown commands produce zero
   always_comb begin
      w_alu_res = '0;
      case (bus.EXE_CMD)
         CMD_MOV: w_alu_res = w_val2;
         CMD_MVN: w_alu_res = ~w_val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: w_alu_res = w_sum[DATA_LEN-1:0];
         CMD_AND: w_alu_res = bus.Val_Rn & w_val2;
         CMD_ORR: w_alu_res = bus.Val_Rn | w_val2;
         CMD_EOR: w_alu_res = bus.Val_Rn ^ w_val2;
         default: w_alu_res = '0;
      endcase
   end

   assign w_br_off     = ADDRESS_LEN'($signed(bus.Signed_imm_24)) << 2;
   assign w_branch     = bus.PC_in + w_br_off;
   assign w_mul_addend = w_is_mla ? bus.Val_Rn : '0;

   exec_mul_iter #(
      .DATA_LEN (DATA_LEN),
      .MUL_BITS (MUL_BITS)
   ) u_mul (
      .clk            (clk),
      .rst            (rst),
      .i_start        (w_mul_start),
      .i_multiplicand (bus.Val_Rm),
      .i_multiplier   (bus.Val_Rs),
      .i_addend       (w_mul_addend),
      .o_busy         (w_mul_busy),
      .o_done         (w_mul_done),
      .o_product      (w_mul_product)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // next state, ready and multiplier start; RESULT can accept the next op while retiring
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_accept     = 1'b0;
      w_mul_start  = 1'b0;
      case (r_state)
         ST_IDLE: w_in_ready = 1'b1;
         ST_MUL_BUSY: begin
            if (w_mul_done) begin
               w_state_next = ST_RESULT;
            end
         end
         ST_RESULT: begin
            w_in_ready = bus.out_ready;
            if (bus.out_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      w_accept = bus.in_valid & w_in_ready;
      if (w_accept) begin
         w_mul_start  = w_is_mul;
         w_state_next = w_is_mul ? ST_MUL_BUSY : ST_RESULT;
      end
   end

   // result, branch target and flags: ALU results land on the accept edge, products when the multiplier finishes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu_res <= '0;
         r_branch  <= '0;
         r_n       <= 1'b0;
         r_z       <= 1'b0;
         r_c       <= 1'b0;
         r_v       <= 1'b0;
         r_mul_s   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_branch <= w_branch;
            r_mul_s  <= bus.S;
            if (!w_is_mul) begin
               r_alu_res <= w_alu_res;
               if (bus.S) begin
                  r_n <= w_alu_res[MSB];
                  r_z <= (w_alu_res == '0);
                  if (w_arith) begin
                     r_c <= w_sum[DATA_LEN];
                     r_v <= w_alu_v;
                  end
               end
            end
         end
         if ((r_state == ST_MUL_BUSY) && w_mul_done) begin
            r_alu_res <= w_mul_product;
            if (r_mul_s) begin
               r_n <= w_mul_product[MSB];
               r_z <= (w_mul_product == '0);
            end
         end
      end
   end

   assign bus.in_ready       = w_in_ready;
   assign bus.out_valid      = (r_state == ST_RESULT);
   assign bus.ALU_Res        = r_alu_res;
   assign bus.Branch_Address = r_branch;
   assign bus.N_stat         = r_n;
   assign bus.Z_stat         = r_z;
   assign bus.C_stat         = r_c;
   assign bus.V_stat         = r_v;

endmodule
